// File: rtl/gate_exhaustive_checker_pkg.sv
// Shared types and constants for the on-chip 2-input gate checker.
// Truth tables are indexed by the {a,b} vector, so bit 3 is the a=1,b=1 result.
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        FINISH
    } state_t;

    typedef logic [3:0] tt_t;

    localparam int TIMER_W = 4;

    localparam tt_t TT_AND  = 4'b1000;
    localparam tt_t TT_NAND = 4'b0111;
    localparam tt_t TT_OR   = 4'b1110;
    localparam tt_t TT_NOR  = 4'b0001;
    localparam tt_t TT_XOR  = 4'b0110;
    localparam tt_t TT_XNOR = 4'b1001;

    function automatic logic vec_mismatch(input tt_t tt, input logic [1:0] vec, input logic res);
        return res != tt[vec];
    endfunction

endpackage

// File: rtl/gate_exhaustive_checker_if.sv
// Signal bundle between the gate checker and whatever drives and observes it.
// The slave side is the checker; the master side requests runs and supplies the gate result.
interface gate_exhaustive_checker_if;
    import gate_check_pkg::*;

    logic       start;
    tt_t        exp_tt;
    logic       dut_result;
    logic       a_out;
    logic       b_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] err_mask;

    modport master (
        output start, exp_tt, dut_result,
        input  a_out, b_out, busy, done, pass, err_count, err_mask
    );

    modport slave (
        input  start, exp_tt, dut_result,
        output a_out, b_out, busy, done, pass, err_count, err_mask
    );

endinterface

// File: rtl/gate_exhaustive_checker_settle_timer.sv
// Loadable down-counter that paces how long each vector is held before sampling.
// Load has priority over decrement; the counter parks at zero.
module settle_timer
    import gate_check_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               dec,
    input  logic [TIMER_W-1:0] load_val,
    output logic               zero
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/gate_exhaustive_checker.sv
// Walks {a,b} through 00..11, samples the gate under test after a settle delay and
// scores each sample against a truth table latched when the run starts.
module gate_exhaustive_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    gate_exhaustive_checker_if.slave  bus
);

    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] vec_q;
    tt_t        tt_q;
    logic       tmr_load;
    logic       tmr_dec;
    logic       tmr_zero;
    logic       mismatch;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (SETTLE_LOAD),
        .zero     (tmr_zero)
    );

    assign mismatch = vec_mismatch(tt_q, vec_q, bus.dut_result);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = SETTLE;
                    tmr_load = 1'b1;
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    state_d = CHECK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            CHECK: begin
                if (vec_q == 2'd3) begin
                    state_d = FINISH;
                end else begin
                    state_d  = SETTLE;
                    tmr_load = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Vector counter, stimulus outputs and scoreboard; results hold until the next run starts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tt_q          <= '0;
            vec_q         <= '0;
            bus.a_out     <= 1'b0;
            bus.b_out     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.err_count <= '0;
            bus.err_mask  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        tt_q                 <= bus.exp_tt;
                        vec_q                <= '0;
                        {bus.a_out, bus.b_out} <= 2'b00;
                        bus.err_count        <= '0;
                        bus.err_mask         <= '0;
                        bus.pass             <= 1'b0;
                        bus.busy             <= 1'b1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        bus.err_count       <= bus.err_count + 3'd1;
                        bus.err_mask[vec_q] <= 1'b1;
                    end
                    if (vec_q == 2'd3) begin
                        bus.done <= 1'b1;
                    end else begin
                        vec_q                  <= vec_q + 2'd1;
                        {bus.a_out, bus.b_out} <= vec_q + 2'd1;
                    end
                end
                FINISH: begin
                    bus.done               <= 1'b0;
                    bus.busy               <= 1'b0;
                    {bus.a_out, bus.b_out} <= 2'b00;
                    bus.pass               <= (bus.err_mask == 4'b0000);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// Directed bench for gate_exhaustive_checker: golden, wrong-gate, single-fault,
// mid-run reset and start-while-busy scenarios with hand-computed results.
module tb_gate_exhaustive_checker;
    import gate_check_pkg::*;

    logic clk;
    logic rst_n;
    int   gate_mode;
    int   checks;
    int   errors;
    int   done_seen;
    int   lat;
    int   d0;
    logic [1:0] ab_hist [0:63];

    gate_exhaustive_checker_if bus ();

    gate_exhaustive_checker #(.SETTLE_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate under test: 0 = NAND, 1 = AND, 2 = XOR with the 11 vector stuck at 1
    always_comb begin
        bus.dut_result = 1'b0;
        case (gate_mode)
            0: bus.dut_result = ~(bus.a_out & bus.b_out);
            1: bus.dut_result = bus.a_out & bus.b_out;
            2: bus.dut_result = (bus.a_out & bus.b_out) ? 1'b1 : (bus.a_out ^ bus.b_out);
            default: bus.dut_result = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_seen++;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepts a run, then waits (bounded) for done; optionally pokes start/exp_tt mid-run.
    task automatic run(input tt_t tt, input int glitch_k, output int latency);
        @(negedge clk);
        bus.exp_tt = tt;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", {7'd0, bus.busy}, 8'd1);
        check("pass_cleared", {7'd0, bus.pass}, 8'd0);
        latency = 0;
        while ((bus.done !== 1'b1) && (latency < 40)) begin
            ab_hist[latency] = {bus.a_out, bus.b_out};
            if (latency == glitch_k) begin
                bus.start  = 1'b1;
                bus.exp_tt = TT_AND;
            end
            if (latency == glitch_k + 2) bus.start = 1'b0;
            @(negedge clk);
            latency++;
        end
        bus.start = 1'b0;
    endtask

    task automatic check_results(input string tag, input logic p, input logic [2:0] cnt,
                                 input logic [3:0] mask);
        @(negedge clk);
        check({tag, "_done_low"}, {7'd0, bus.done}, 8'd0);
        check({tag, "_busy_low"}, {7'd0, bus.busy}, 8'd0);
        check({tag, "_ab_idle"}, {6'd0, bus.a_out, bus.b_out}, 8'd0);
        check({tag, "_pass"}, {7'd0, bus.pass}, {7'd0, p});
        check({tag, "_err_count"}, {5'd0, bus.err_count}, {5'd0, cnt});
        check({tag, "_err_mask"}, {4'd0, bus.err_mask}, {4'd0, mask});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        gate_mode = 0;
        rst_n     = 1'b0;
        bus.start  = 1'b0;
        bus.exp_tt = 4'b0000;

        // 1. reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ab", {6'd0, bus.a_out, bus.b_out}, 8'd0);
        check("rst_busy", {7'd0, bus.busy}, 8'd0);
        check("rst_done", {7'd0, bus.done}, 8'd0);
        check("rst_pass", {7'd0, bus.pass}, 8'd0);
        check("rst_err_count", {5'd0, bus.err_count}, 8'd0);
        check("rst_err_mask", {4'd0, bus.err_mask}, 8'd0);
        check("rst_state", {6'd0, dut.state_q}, {6'd0, IDLE});
        rst_n = 1'b1;

        // 2. golden NAND
        gate_mode = 0;
        d0 = done_seen;
        run(TT_NAND, -1, lat);
        check("nand_latency", 8'(lat), 8'd12);
        check("nand_ab_k0", {6'd0, ab_hist[0]}, 8'd0);
        check("nand_ab_k2", {6'd0, ab_hist[2]}, 8'd0);
        check("nand_ab_k3", {6'd0, ab_hist[3]}, 8'd1);
        check("nand_ab_k5", {6'd0, ab_hist[5]}, 8'd1);
        check("nand_ab_k6", {6'd0, ab_hist[6]}, 8'd2);
        check("nand_ab_k9", {6'd0, ab_hist[9]}, 8'd3);
        check_results("nand", 1'b1, 3'd0, 4'b0000);
        check("nand_done_pulses", 8'(done_seen - d0), 8'd1);

        // 3. wrong gate: AND checked against NAND table
        gate_mode = 1;
        run(TT_NAND, -1, lat);
        check("and_latency", 8'(lat), 8'd12);
        check_results("and", 1'b0, 3'd4, 4'b1111);

        // 4. single fault on vector 11
        gate_mode = 2;
        run(TT_XOR, -1, lat);
        check("xor_latency", 8'(lat), 8'd12);
        check_results("xorf", 1'b0, 3'd1, 4'b1000);

        // 5. mid-run reset at cycle 5
        gate_mode = 0;
        d0 = done_seen;
        @(negedge clk);
        bus.exp_tt = TT_NAND;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", {7'd0, bus.busy}, 8'd0);
        check("midrst_ab", {6'd0, bus.a_out, bus.b_out}, 8'd0);
        check("midrst_err_count", {5'd0, bus.err_count}, 8'd0);
        check("midrst_err_mask", {4'd0, bus.err_mask}, 8'd0);
        check("midrst_state", {6'd0, dut.state_q}, {6'd0, IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_done", 8'(done_seen - d0), 8'd0);
        run(TT_NAND, -1, lat);
        check("restart_latency", 8'(lat), 8'd12);
        check_results("restart", 1'b1, 3'd0, 4'b0000);

        // 6. start and exp_tt poked while busy
        d0 = done_seen;
        run(TT_NAND, 3, lat);
        check("busy_latency", 8'(lat), 8'd12);
        check_results("busy", 1'b1, 3'd0, 4'b0000);
        repeat (16) @(negedge clk);
        check("busy_done_pulses", 8'(done_seen - d0), 8'd1);

        // 7. start held high: re-accepted in the first IDLE cycle after FINISH
        @(negedge clk);
        bus.exp_tt = TT_NAND;
        bus.start  = 1'b1;
        @(negedge clk);
        lat = 0;
        while ((bus.done !== 1'b1) && (lat < 40)) begin
            @(negedge clk);
            lat++;
        end
        check("held_latency", 8'(lat), 8'd12);
        @(negedge clk);
        check("held_finish_busy", {7'd0, bus.busy}, 8'd0);
        @(negedge clk);
        check("held_rearm_busy", {7'd0, bus.busy}, 8'd1);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("held_idle", {7'd0, bus.busy}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
